// File: rtl/fifo_ctrl_sdp.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_sdp
//   First-word-fall-through FIFO controller for an external simple dual-port RAM
//   (one write port, synchronous read with one cycle of latency, old data on a
//   same-address read/write). A two-entry output buffer hides the RAM read
//   latency, so a continuous stream moves one word per clock in each direction.
//
//   Optional feature macro: FIFO_ALMOST_FLAGS_EN
//     When defined, adds the AF_LEVEL/AE_LEVEL parameters and the almost_full /
//     almost_empty outputs. When undefined they are absent.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   s_valid/s_ready/s_data   write-side stream (s_ready = RAM not full)
//   m_valid/m_ready/m_data   read-side stream (head of FIFO, registered)
//   count                 total occupancy: RAM words + read in flight + buffer
//   ram_we/ram_waddr/ram_din  RAM write port
//   ram_raddr/ram_dout    RAM read port (dout valid one clock after issue)
//   almost_full/almost_empty  occupancy thresholds (FIFO_ALMOST_FLAGS_EN only)
// -----------------------------------------------------------------------------
module fifo_ctrl_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  // mem_cnt value meaning "RAM full" (DEPTH = 2**ADDR_WIDTH)
  localparam logic [ADDR_WIDTH:0] MEM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;   // head entry, drives m_data
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

  logic push;
  logic pop;
  logic rd;
  logic capture;

  // Write side: gated by rst_n so the RAM sees no write while reset is held.
  assign s_ready   = (mem_cnt_q != MEM_FULL);
  assign push      = s_valid & s_ready & rst_n;
  assign ram_we    = push;
  assign ram_waddr = wptr_q;
  assign ram_din   = s_data;
  assign ram_raddr = rptr_q;

  assign m_valid = (ob_cnt_q != 2'd0);
  assign m_data  = ob0_q;
  assign pop     = m_valid & m_ready;
  assign capture = rd_inflight_q;

  // Issue a read only if the buffer will have room for it when it lands,
  // counting the read already in flight and a pop happening this cycle.
  assign rd = (mem_cnt_q != '0) &&
              (({1'b0, ob_cnt_q} + {2'b00, rd_inflight_q}) <= (3'd1 + {2'b00, pop}));

  assign count = {1'b0, mem_cnt_q}
               + {{(ADDR_WIDTH+1){1'b0}}, rd_inflight_q}
               + {{ADDR_WIDTH{1'b0}}, ob_cnt_q};

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    mem_cnt_d     = mem_cnt_q;
    rd_inflight_d = rd;
    ob_cnt_d      = ob_cnt_q;
    ob0_d         = ob0_q;
    ob1_d         = ob1_q;

    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd) begin
      rptr_d = rptr_q + 1'b1;
    end

    if (push && !rd) begin
      mem_cnt_d = mem_cnt_q + 1'b1;
    end else if (!push && rd) begin
      mem_cnt_d = mem_cnt_q - 1'b1;
    end

    // Pop shifts the second entry forward; a captured word then lands in the
    // first free slot after the shift, keeping arrival order.
    if (pop) begin
      ob0_d = ob1_q;
    end
    if (capture) begin
      if ((ob_cnt_q == 2'd0) || ((ob_cnt_q == 2'd1) && pop)) begin
        ob0_d = ram_dout;
      end else begin
        ob1_d = ram_dout;
      end
    end

    if (capture && !pop) begin
      ob_cnt_d = ob_cnt_q + 2'd1;
    end else if (!capture && pop) begin
      ob_cnt_d = ob_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      ob_cnt_q      <= '0;
      ob0_q         <= '0;
      ob1_q         <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      ob_cnt_q      <= ob_cnt_d;
      ob0_q         <= ob0_d;
      ob1_q         <= ob1_d;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH+1:0] AF_CNT = (ADDR_WIDTH+2)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH+1:0] AE_CNT = (ADDR_WIDTH+2)'(AE_LEVEL);

  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
`endif

endmodule
